counter_arbiter: RTL and testbench



---
 rtl/counter_arbiter.sv | 129 ++++++++++++
 tb/tb_counter_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin owner of a shared external 4-bit up-counter
//
// Grants one requester at a time, clears the shared counter, enables it until
// it reaches that requester's latched target length, then pulses done.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   req         per-requester request level, held until done or abort
//   req_len     target count for requester i at bits [4i+3:4i]
//   gnt         one-hot grant, zero when idle
//   done        one-cycle completion pulse to the granted requester
//   err         one-cycle pulse when the counter overshot the target
//   busy        high whenever a job is in progress
//   cnt_reset   synchronous clear to the counter
//   cnt_enable  increment enable to the counter
//   cnt_value   registered value returned by the counter
module counter_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              cnt_reset,
  output logic              cnt_enable,
  input  logic [3:0]        cnt_value
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] g;
  logic [3:0]    len_q;

  logic [IW-1:0] pick;
  logic [3:0]    pick_len;
  logic          found;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin search: first set request starting just above the last
  // served index, wrapping modulo NREQ. The last index itself is searched
  // last, so a lone requester can still be re-granted.
  always_comb begin
    pick     = '0;
    pick_len = '0;
    found    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(last) + i) % NREQ]) begin
        found    = 1'b1;
        pick     = IW'((int'(last) + i) % NREQ);
        pick_len = req_len[((int'(last) + i) % NREQ) * 4 +: 4];
      end
    end
  end

  // The counter is cleared during reset as well, so it is never left with a
  // stale value from an interrupted job.
  assign cnt_reset  = reset || (state == CLEAR);

  // Enable stops at the target, so a target of 15 never wraps the counter.
  assign cnt_enable = (state == RUN) && (cnt_value < len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= IW'(NREQ - 1);
      g     <= '0;
      len_q <= '0;
      gnt   <= '0;
      done  <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            g     <= pick;
            len_q <= pick_len;
            gnt   <= onehot(pick);
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          state <= RUN;
        end
        RUN: begin
          // Abort takes priority: a withdrawn request never sees done.
          if (!req[g]) begin
            last  <= g;
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt_value >= len_q) begin
            done  <= onehot(g);
            err   <= (cnt_value > len_q);
            state <= DONE;
          end
        end
        DONE: begin
          last  <= g;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - self-checking bench for counter_arbiter
module tb_counter_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] req_len = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              busy;
  logic              cnt_reset;
  logic              cnt_enable;
  logic [3:0]        cv = 4'd0;
  bit                fault = 1'b0;

  always #5 clk = ~clk;

  counter_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_len    (req_len),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .cnt_reset  (cnt_reset),
    .cnt_enable (cnt_enable),
    .cnt_value  (cv)
  );

  // External shared counter; the fault mode skips from 2 straight to 4.
  always @(posedge clk) begin
    if (cnt_reset) cv <= 4'd0;
    else if (cnt_enable) cv <= (fault && cv == 4'd2) ? 4'd4 : cv + 4'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Job-level model: an active job with its owner, target, whether it is
  // still in its clear cycle, and whether it has just finished.
  bit m_act = 1'b0;
  bit m_clear = 1'b0;
  bit m_fin = 1'b0;
  bit m_err = 1'b0;
  int m_g = 0;
  int m_len = 0;
  int m_last = NREQ - 1;

  int g_cyc[$];
  int g_idx[$];
  int d_cyc[$];
  int d_idx[$];
  int d_cv[$];
  int d_err[$];
  int en_cnt = 0;
  logic [NREQ-1:0] prev_gnt = '0;

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_done;
    logic e_rst;
    logic e_en;
    e_gnt  = '0;
    e_done = '0;
    if (m_act) e_gnt[m_g] = 1'b1;
    if (m_fin) e_done[m_g] = 1'b1;
    e_rst = reset || (m_act && m_clear);
    e_en  = m_act && !m_clear && !m_fin && (int'(cv) < m_len);
    if (chk_en) begin
      cmp("gnt", 32'(gnt), 32'(e_gnt));
      cmp("done", 32'(done), 32'(e_done));
      cmp("err", 32'(err), 32'(m_fin && m_err));
      cmp("busy", 32'(busy), 32'(m_act));
      cmp("cnt_reset", 32'(cnt_reset), 32'(e_rst));
      cmp("cnt_enable", 32'(cnt_enable), 32'(e_en));
    end

    if (gnt != '0 && gnt != prev_gnt) begin
      g_cyc.push_back(cyc);
      g_idx.push_back(oh_idx(gnt));
    end
    prev_gnt = gnt;
    if (done != '0) begin
      d_cyc.push_back(cyc);
      d_idx.push_back(oh_idx(done));
      d_cv.push_back(int'(cv));
      d_err.push_back(int'(err));
    end
    if (cnt_enable) en_cnt++;

    if (reset) begin
      m_act  = 1'b0;
      m_fin  = 1'b0;
      m_last = NREQ - 1;
    end else if (!m_act) begin
      if (req != '0) begin
        for (int i = 1; i <= NREQ; i++) begin
          if (req[(m_last + i) % NREQ]) begin
            m_g = (m_last + i) % NREQ;
            break;
          end
        end
        m_len   = int'(req_len[m_g*4 +: 4]);
        m_act   = 1'b1;
        m_clear = 1'b1;
        m_fin   = 1'b0;
      end
    end else if (m_fin) begin
      m_act  = 1'b0;
      m_fin  = 1'b0;
      m_last = m_g;
    end else if (m_clear) begin
      m_clear = 1'b0;
    end else if (!req[m_g]) begin
      m_act  = 1'b0;
      m_last = m_g;
    end else if (int'(cv) >= m_len) begin
      m_fin = 1'b1;
      m_err = (int'(cv) > m_len);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_cyc.delete(); g_idx.delete();
    d_cyc.delete(); d_idx.delete(); d_cv.delete(); d_err.delete();
    en_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_len(input int i, input logic [3:0] v);
    req_len[i*4 +: 4] = v;
  endtask

  task automatic wait_done(input int n, input int max_cycles);
    int k;
    k = 0;
    while (d_cyc.size() < n && k < max_cycles) begin
      tick();
      k++;
    end
    if (d_cyc.size() < n) begin
      checks++;
      failures++;
      $display("FAIL wait_done timeout: got %0d done pulses expected %0d", d_cyc.size(), n);
    end
  endtask

  int t;
  int k;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset values
    tick();
    chk_en = 1'b1;
    cmp("rst_gnt", 32'(gnt), 32'h0);
    cmp("rst_busy", 32'(busy), 32'h0);
    cmp("rst_done", 32'(done), 32'h0);
    cmp("rst_cnt_enable", 32'(cnt_enable), 32'h0);
    cmp("rst_cnt_reset", 32'(cnt_reset), 32'h1);
    tick();
    reset = 1'b0;
    #1;
    cmp("rel_cnt_reset", 32'(cnt_reset), 32'h0);
    tick();

    // Single job, length 3
    set_len(0, 4'd3);
    clear_logs();
    t = cyc;
    req = 4'b0001;
    wait_done(1, 40);
    req = '0;
    if (g_cyc.size() >= 1 && d_cyc.size() >= 1) begin
      cmp("single_gnt_cycle", 32'(g_cyc[0]), 32'(t + 1));
      cmp("single_done_cycle", 32'(d_cyc[0]), 32'(t + 6));
      cmp("single_done_cv", 32'(d_cv[0]), 32'd3);
    end
    cmp("single_en_cycles", 32'(en_cnt), 32'd3);

    // Round robin, all lengths 1
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 4'd1);
    clear_logs();
    t = cyc;
    req = 4'b1111;
    wait_done(5, 100);
    req = '0;
    cmp("rr_grant_count", 32'(g_idx.size()), 32'd5);
    if (g_idx.size() >= 5 && d_idx.size() >= 5) begin
      cmp("rr_first_gnt_cycle", 32'(g_cyc[0]), 32'(t + 1));
      for (int i = 0; i < 5; i++) begin
        cmp("rr_gnt_order", 32'(g_idx[i]), 32'(rr_exp[i]));
        cmp("rr_done_order", 32'(d_idx[i]), 32'(rr_exp[i]));
        if (i > 0) cmp("rr_period", 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
      end
    end

    // Length 0
    do_reset();
    set_len(0, 4'd0);
    clear_logs();
    t = cyc;
    req = 4'b0001;
    wait_done(1, 20);
    req = '0;
    if (d_cyc.size() >= 1) cmp("len0_done_cycle", 32'(d_cyc[0]), 32'(t + 3));
    cmp("len0_en_cycles", 32'(en_cnt), 32'd0);

    // Length 15
    do_reset();
    set_len(0, 4'd15);
    clear_logs();
    t = cyc;
    req = 4'b0001;
    wait_done(1, 40);
    req = '0;
    if (d_cyc.size() >= 1) begin
      cmp("len15_done_cycle", 32'(d_cyc[0]), 32'(t + 18));
      cmp("len15_done_cv", 32'(d_cv[0]), 32'd15);
    end
    cmp("len15_en_cycles", 32'(en_cnt), 32'd15);
    cmp("len15_no_wrap", 32'(cv), 32'd15);

    // Abort of requester 2 on its 4th RUN cycle, requester 3 pending
    do_reset();
    set_len(2, 4'd10);
    set_len(3, 4'd2);
    clear_logs();
    t = cyc;
    req = 4'b1100;
    repeat (5) tick();
    req = 4'b1000;
    tick();
    cmp("abort_busy", 32'(busy), 32'h0);
    cmp("abort_gnt", 32'(gnt), 32'h0);
    cmp("abort_no_done", 32'(d_cyc.size()), 32'd0);
    wait_done(1, 30);
    req = '0;
    if (g_idx.size() >= 2 && d_idx.size() >= 1) begin
      cmp("abort_first_gnt", 32'(g_idx[0]), 32'd2);
      cmp("abort_next_gnt", 32'(g_idx[1]), 32'd3);
      cmp("abort_next_gnt_cycle", 32'(g_cyc[1]), 32'(t + 7));
      cmp("abort_done_idx", 32'(d_idx[0]), 32'd3);
    end

    // Reset in the middle of a run at counter value 5
    do_reset();
    set_len(0, 4'd10);
    set_len(1, 4'd2);
    set_len(3, 4'd2);
    clear_logs();
    req = 4'b0001;
    k = 0;
    while (cv != 4'd5 && k < 30) begin
      tick();
      k++;
    end
    cmp("midrst_reached_5", 32'(cv), 32'd5);
    reset = 1'b1;
    tick();
    cmp("midrst_gnt", 32'(gnt), 32'h0);
    cmp("midrst_busy", 32'(busy), 32'h0);
    cmp("midrst_cv", 32'(cv), 32'd0);
    reset = 1'b0;
    req = 4'b1010;
    clear_logs();
    wait_done(1, 30);
    req = '0;
    if (g_idx.size() >= 1) cmp("midrst_first_gnt", 32'(g_idx[0]), 32'd1);

    // Faulty counter jumps 2 -> 4 with length 3
    do_reset();
    fault = 1'b1;
    set_len(0, 4'd3);
    clear_logs();
    t = cyc;
    req = 4'b0001;
    wait_done(1, 30);
    req = '0;
    if (d_cyc.size() >= 1) begin
      cmp("fault_err", 32'(d_err[0]), 32'd1);
      cmp("fault_done_idx", 32'(d_idx[0]), 32'd0);
      cmp("fault_done_cv", 32'(d_cv[0]), 32'd4);
      cmp("fault_done_cycle", 32'(d_cyc[0]), 32'(t + 6));
    end
    cmp("fault_idle_busy", 32'(busy), 32'h0);
    cmp("fault_idle_err", 32'(err), 32'h0);
    fault = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
